// File: rtl/asu_ddr5_cfg_pkg.sv
// Purpose: shared types and constants for the DDR5 PHY configuration sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package asu_ddr5_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        WR_CRC,
        WR_FREQ,
        SETTLE,
        DONE,
        ERR
    } cfg_state_e;

    // Register file word map
    localparam int unsigned CRC_ADDR  = 0;
    localparam int unsigned FREQ_ADDR = 1;

    // Frequency ratio encoding that the PHY does not support
    localparam logic [1:0] FREQ_RATIO_RSVD = 2'b11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/asu_ddr5_cfg_timer.sv
// Purpose: loadable down-counter with a zero flag, shared by drain timeout and settle count.
// Latency: load/decrement take effect on the next clk_i edge; zero is decoded from the count register.
// Backpressure: none; decrement saturates at zero.
// Ports: clk_i/rst_i clock and sync reset; load/load_val load the count (load wins over dec);
//        dec decrements by one; zero is high while the count is zero.
module asu_ddr5_cfg_timer #(
    parameter int pWIDTH = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load,
    input  logic [pWIDTH-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [pWIDTH-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/asu_ddr5_cfg_sequencer.sv
// Purpose: reprograms PHY CRC mode / DFI freq ratio at run time behind a datapath drain.
// Latency: req to ack = 4 + drain wait + pSETTLE_CYCLES cycles (8 with an idle datapath and 4 settle cycles).
// Backpressure: 4-phase req/ack; ack is held until req drops, dp_hold_o stalls the write datapath.
// Ports: cfg_req_i/cfg_crc_mode_i/cfg_freq_ratio_i request in; cfg_ack_o/cfg_err_o/cfg_busy_o status out;
//        dp_idle_i/dp_hold_o datapath drain handshake; rf_wr_en_o/rf_addr_o/rf_wdata_o register file
//        write port; cur_crc_mode_o/cur_freq_ratio_o last successfully programmed values.
module asu_ddr5_cfg_sequencer
    import asu_ddr5_cfg_pkg::*;
#(
    parameter int         pDATA_WIDTH    = 4,
    parameter int         pADDR_WIDTH    = 1,
    parameter int         pDRAIN_TIMEOUT = 16,
    parameter int         pSETTLE_CYCLES = 4,
    parameter logic       pCRC_MODE      = 1'b1,
    parameter logic [1:0] pFREQ_RATIO    = 2'b00
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_req_i,
    input  logic                   cfg_crc_mode_i,
    input  logic [1:0]             cfg_freq_ratio_i,
    output logic                   cfg_ack_o,
    output logic                   cfg_err_o,
    output logic                   cfg_busy_o,
    input  logic                   dp_idle_i,
    output logic                   dp_hold_o,
    output logic                   rf_wr_en_o,
    output logic [pADDR_WIDTH-1:0] rf_addr_o,
    output logic [pDATA_WIDTH-1:0] rf_wdata_o,
    output logic                   cur_crc_mode_o,
    output logic [1:0]             cur_freq_ratio_o
);

    localparam int TMR_W = $clog2(max_int(pDRAIN_TIMEOUT, pSETTLE_CYCLES) + 1);

    // Counts run down to zero inclusive, so load N-1 to spend exactly N cycles in a state.
    localparam logic [TMR_W-1:0] DRAIN_LOAD  = TMR_W'(pDRAIN_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'((pSETTLE_CYCLES > 0) ? (pSETTLE_CYCLES - 1) : 0);

    cfg_state_e state_q, state_d;

    logic       crc_q;
    logic [1:0] ratio_q;
    logic       cur_crc_q;
    logic [1:0] cur_ratio_q;
    logic       capture;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic             tmr_dec;
    logic             tmr_zero;

    asu_ddr5_cfg_timer #(
        .pWIDTH (TMR_W)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            crc_q       <= 1'b0;
            ratio_q     <= 2'b00;
            cur_crc_q   <= pCRC_MODE;
            cur_ratio_q <= pFREQ_RATIO;
        end else begin
            state_q <= state_d;
            if (capture) begin
                crc_q   <= cfg_crc_mode_i;
                ratio_q <= cfg_freq_ratio_i;
            end
            // Both words are committed once WR_FREQ retires.
            if (state_q == WR_FREQ) begin
                cur_crc_q   <= crc_q;
                cur_ratio_q <= ratio_q;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        capture      = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        cfg_ack_o    = 1'b0;
        cfg_err_o    = 1'b0;
        dp_hold_o    = 1'b0;
        rf_wr_en_o   = 1'b0;
        rf_addr_o    = '0;
        rf_wdata_o   = '0;

        case (state_q)
            IDLE: begin
                if (cfg_req_i) begin
                    capture = 1'b1;
                    if (cfg_freq_ratio_i == FREQ_RATIO_RSVD) begin
                        state_d = ERR;
                    end else begin
                        state_d      = HOLD;
                        tmr_load     = 1'b1;
                        tmr_load_val = DRAIN_LOAD;
                    end
                end
            end
            HOLD: begin
                dp_hold_o = 1'b1;
                if (dp_idle_i) begin
                    state_d = WR_CRC;
                end else if (tmr_zero) begin
                    state_d = ERR;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            WR_CRC: begin
                dp_hold_o  = 1'b1;
                rf_wr_en_o = 1'b1;
                rf_addr_o  = pADDR_WIDTH'(CRC_ADDR);
                rf_wdata_o = pDATA_WIDTH'(crc_q);
                state_d    = WR_FREQ;
            end
            WR_FREQ: begin
                dp_hold_o  = 1'b1;
                rf_wr_en_o = 1'b1;
                rf_addr_o  = pADDR_WIDTH'(FREQ_ADDR);
                rf_wdata_o = pDATA_WIDTH'(ratio_q);
                if (pSETTLE_CYCLES == 0) begin
                    state_d = DONE;
                end else begin
                    state_d      = SETTLE;
                    tmr_load     = 1'b1;
                    tmr_load_val = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                dp_hold_o = 1'b1;
                if (tmr_zero) begin
                    state_d = DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DONE: begin
                cfg_ack_o = 1'b1;
                if (!cfg_req_i) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                cfg_ack_o = 1'b1;
                cfg_err_o = 1'b1;
                if (!cfg_req_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cfg_busy_o       = (state_q != IDLE);
    assign cur_crc_mode_o   = cur_crc_q;
    assign cur_freq_ratio_o = cur_ratio_q;

endmodule

// File: tb/tb_asu_ddr5_cfg_sequencer.sv
// Purpose: directed self-checking bench for the DDR5 PHY configuration sequencer.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpressure: register file writes are checked against a queue of expected writes.
module tb_asu_ddr5_cfg_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       cfg_req_i = 1'b0;
    logic       cfg_crc_mode_i = 1'b0;
    logic [1:0] cfg_freq_ratio_i = 2'b00;
    logic       cfg_ack_o;
    logic       cfg_err_o;
    logic       cfg_busy_o;
    logic       dp_idle_i = 1'b1;
    logic       dp_hold_o;
    logic       rf_wr_en_o;
    logic [0:0] rf_addr_o;
    logic [3:0] rf_wdata_o;
    logic       cur_crc_mode_o;
    logic [1:0] cur_freq_ratio_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected register file writes: {addr, data}
    logic [4:0] wr_q[$];

    asu_ddr5_cfg_sequencer #(
        .pDATA_WIDTH    (4),
        .pADDR_WIDTH    (1),
        .pDRAIN_TIMEOUT (16),
        .pSETTLE_CYCLES (4),
        .pCRC_MODE      (1'b1),
        .pFREQ_RATIO    (2'b00)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .cfg_req_i        (cfg_req_i),
        .cfg_crc_mode_i   (cfg_crc_mode_i),
        .cfg_freq_ratio_i (cfg_freq_ratio_i),
        .cfg_ack_o        (cfg_ack_o),
        .cfg_err_o        (cfg_err_o),
        .cfg_busy_o       (cfg_busy_o),
        .dp_idle_i        (dp_idle_i),
        .dp_hold_o        (dp_hold_o),
        .rf_wr_en_o       (rf_wr_en_o),
        .rf_addr_o        (rf_addr_o),
        .rf_wdata_o       (rf_wdata_o),
        .cur_crc_mode_o   (cur_crc_mode_o),
        .cur_freq_ratio_o (cur_freq_ratio_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_writes(input logic crc, input logic [1:0] ratio);
        wr_q.push_back({1'b0, 4'(crc)});
        wr_q.push_back({1'b1, 4'(ratio)});
    endtask

    // Ticks until ack or bound; returns the number of edges taken.
    task automatic wait_ack(input int bound, input string tag, output int cyc);
        cyc = 0;
        while (cfg_ack_o !== 1'b1 && cyc < bound) begin
            tick();
            cyc++;
        end
        if (cfg_ack_o !== 1'b1) chk({tag, "_ack_timeout"}, 32'(cfg_ack_o), 32'd1);
    endtask

    // Write scoreboard: every strobe must match the oldest expected write.
    always @(negedge clk_i) begin
        if (rf_wr_en_o === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write", {27'd0, rf_addr_o, rf_wdata_o}, 32'hdead);
            end else begin
                chk("rf_write", {27'd0, rf_addr_o, rf_wdata_o}, 32'(wr_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int hold_cnt;

        // ---------------- reset defaults
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        chk("rst_cur_crc",   32'(cur_crc_mode_o),   32'd1);
        chk("rst_cur_ratio", 32'(cur_freq_ratio_o), 32'd0);
        chk("rst_ack",       32'(cfg_ack_o),        32'd0);
        chk("rst_err",       32'(cfg_err_o),        32'd0);
        chk("rst_hold",      32'(dp_hold_o),        32'd0);
        chk("rst_busy",      32'(cfg_busy_o),       32'd0);
        chk("rst_wr_en",     32'(rf_wr_en_o),       32'd0);

        // ---------------- nominal: crc=0 ratio=01, idle datapath
        push_writes(1'b0, 2'b01);
        cfg_crc_mode_i   = 1'b0;
        cfg_freq_ratio_i = 2'b01;
        cfg_req_i        = 1'b1;
        tick();                          // edge 0 -> HOLD
        cfg_crc_mode_i   = 1'b1;         // post-capture changes must be ignored
        cfg_freq_ratio_i = 2'b10;
        chk("nom_c1_busy", 32'(cfg_busy_o), 32'd1);
        chk("nom_c1_hold", 32'(dp_hold_o),  32'd1);
        chk("nom_c1_wr",   32'(rf_wr_en_o), 32'd0);
        tick();                          // WR_CRC
        chk("nom_c2_wr",   32'(rf_wr_en_o), 32'd1);
        chk("nom_c2_addr", 32'(rf_addr_o),  32'd0);
        tick();                          // WR_FREQ
        chk("nom_c3_addr", 32'(rf_addr_o),  32'd1);
        chk("nom_c3_data", 32'(rf_wdata_o), 32'd1);
        chk("nom_c3_cur_ratio_old", 32'(cur_freq_ratio_o), 32'd0);
        tick();                          // SETTLE first cycle
        chk("nom_c4_hold", 32'(dp_hold_o), 32'd1);
        chk("nom_c4_cur_ratio", 32'(cur_freq_ratio_o), 32'd1);
        chk("nom_c4_cur_crc",   32'(cur_crc_mode_o),   32'd0);
        wait_ack(20, "nom", cyc);
        chk("nom_ack_cycle", 32'(cyc + 4), 32'd8);
        chk("nom_err",  32'(cfg_err_o), 32'd0);
        chk("nom_hold_released", 32'(dp_hold_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nom_ack_held", 32'(cfg_ack_o), 32'd1);
        end
        chk("nom_no_retrigger_busy", 32'(cfg_busy_o), 32'd1);
        cfg_req_i = 1'b0;
        tick();
        chk("nom_idle_ack",  32'(cfg_ack_o),  32'd0);
        chk("nom_idle_busy", 32'(cfg_busy_o), 32'd0);

        // ---------------- drain wait: idle low for 5 cycles
        push_writes(1'b1, 2'b10);
        dp_idle_i        = 1'b0;
        cfg_crc_mode_i   = 1'b1;
        cfg_freq_ratio_i = 2'b10;
        cfg_req_i        = 1'b1;
        tick();                          // edge 0 -> HOLD
        hold_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (dp_hold_o === 1'b1 && rf_wr_en_o === 1'b0) hold_cnt++;
            tick();
        end
        chk("drain_hold_cycles", 32'(hold_cnt), 32'd5);
        dp_idle_i = 1'b1;
        chk("drain_still_hold", 32'(dp_hold_o), 32'd1);
        chk("drain_no_wr_yet",  32'(rf_wr_en_o), 32'd0);
        tick();
        chk("drain_wr_crc_next", 32'(rf_wr_en_o), 32'd1);
        dp_idle_i = 1'b0;                // dropping idle after hold must not matter
        wait_ack(20, "drain", cyc);
        chk("drain_err",       32'(cfg_err_o),        32'd0);
        chk("drain_cur_crc",   32'(cur_crc_mode_o),   32'd1);
        chk("drain_cur_ratio", 32'(cur_freq_ratio_o), 32'd2);
        cfg_req_i = 1'b0;
        tick();

        // ---------------- timeout: idle stuck low
        cfg_crc_mode_i   = 1'b0;
        cfg_freq_ratio_i = 2'b01;
        cfg_req_i        = 1'b1;
        tick();                          // edge 0 -> HOLD
        hold_cnt = 0;
        cyc = 1;
        while (cfg_ack_o !== 1'b1 && cyc < 40) begin
            if (dp_hold_o === 1'b1) hold_cnt++;
            tick();
            cyc++;
        end
        chk("tmo_ack",         32'(cfg_ack_o),        32'd1);
        chk("tmo_ack_cycle",   32'(cyc),              32'd17);
        chk("tmo_hold_cycles", 32'(hold_cnt),         32'd16);
        chk("tmo_err",         32'(cfg_err_o),        32'd1);
        chk("tmo_hold_off",    32'(dp_hold_o),        32'd0);
        chk("tmo_cur_crc",     32'(cur_crc_mode_o),   32'd1);
        chk("tmo_cur_ratio",   32'(cur_freq_ratio_o), 32'd2);
        cfg_req_i = 1'b0;
        dp_idle_i = 1'b1;
        tick();

        // ---------------- reserved ratio
        cfg_freq_ratio_i = 2'b11;
        cfg_req_i        = 1'b1;
        tick();
        chk("rsvd_ack",  32'(cfg_ack_o), 32'd1);
        chk("rsvd_err",  32'(cfg_err_o), 32'd1);
        chk("rsvd_hold", 32'(dp_hold_o), 32'd0);
        chk("rsvd_cur_ratio", 32'(cur_freq_ratio_o), 32'd2);
        cfg_req_i = 1'b0;
        tick();
        chk("rsvd_idle", 32'(cfg_busy_o), 32'd0);

        // ---------------- reset in SETTLE, then a clean request
        push_writes(1'b0, 2'b01);
        cfg_crc_mode_i   = 1'b0;
        cfg_freq_ratio_i = 2'b01;
        cfg_req_i        = 1'b1;
        for (int i = 0; i < 4; i++) tick();   // SETTLE first cycle
        chk("mid_in_settle_cur", 32'(cur_freq_ratio_o), 32'd1);
        rst_i     = 1'b1;
        cfg_req_i = 1'b0;
        tick();
        rst_i = 1'b0;
        chk("mid_rst_busy",  32'(cfg_busy_o),       32'd0);
        chk("mid_rst_hold",  32'(dp_hold_o),        32'd0);
        chk("mid_rst_ack",   32'(cfg_ack_o),        32'd0);
        chk("mid_rst_wr",    32'(rf_wr_en_o),       32'd0);
        chk("mid_rst_wdata", 32'(rf_wdata_o),       32'd0);
        chk("mid_rst_crc",   32'(cur_crc_mode_o),   32'd1);
        chk("mid_rst_ratio", 32'(cur_freq_ratio_o), 32'd0);
        tick();
        push_writes(1'b1, 2'b10);
        cfg_crc_mode_i   = 1'b1;
        cfg_freq_ratio_i = 2'b10;
        cfg_req_i        = 1'b1;
        tick();
        wait_ack(20, "post_rst", cyc);
        chk("post_rst_ack_cycle", 32'(cyc + 1), 32'd8);
        chk("post_rst_err",   32'(cfg_err_o),        32'd0);
        chk("post_rst_ratio", 32'(cur_freq_ratio_o), 32'd2);
        cfg_req_i = 1'b0;
        tick();
        tick();
        chk("all_writes_seen", 32'(wr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
